a2d_arbiter: RTL
================

// Module: a2d_arbiter
// PURPOSE
// - Shares the single A2D converter interface (strt_cnv/chnnl/cnv_cmplt/res) between two requesters.
// - Requester 0 is the slide-pot channel scanner; requester 1 is an auxiliary sampler (e.g. battery/temp).
// - Owns the conversion sequence: select winner, drive channel, pulse start, wait for complete,
//   return the 12-bit result with a one-cycle done strobe.
// PARAMETERS
// - RES_W     12  result width from the A2D
// - CH_W      3   channel select width
// - FIXED_PRI 0   0 = round-robin on ties; 1 = req1 always wins ties
// - TIMEOUT   64  WAIT-state cycle limit (used only with A2D_TIMEOUT_EN)
// PORTS
// - clk        in   1      system clock, all logic rising-edge
// - rst_n      in   1      asynchronous active-low reset
// - req0       in   1      requester 0 conversion request (level)
// - chnl0      in   CH_W   requester 0 channel, stable while req0 high
// - req1       in   1      requester 1 conversion request (level)
// - chnl1      in   CH_W   requester 1 channel, stable while req1 high
// - gnt0/gnt1  out  1      owner indication, one-hot or zero
// - done0/done1 out 1      one-cycle completion strobe to owner
// - res        out  RES_W  last conversion result, valid when done high, held until next completion
// - err        out  1      timeout flag, valid with done strobe
// - busy       out  1      high in any state other than IDLE
// - strt_cnv   out  1      one-cycle start pulse to A2D
// - chnnl      out  CH_W   channel driven to A2D, held from grant through DONE
// - cnv_cmplt  in   1      A2D conversion-complete strobe
// - a2d_res    in   RES_W  A2D result, valid when cnv_cmplt high
// BEHAVIOUR
// - Reset: state=IDLE; gnt*, done*, strt_cnv, busy, err = 0; chnnl = 0; res = 0; rr pointer = "last served 1".
// - FSM IDLE -> START -> WAIT -> DONE -> IDLE; all outputs registered / Moore.
// - IDLE: stays while req0 = req1 = 0. Any req at an edge: pick winner, latch its chnl into chnnl,
//   set its gnt, go to START.
// - Ties: FIXED_PRI=0 -> requester not served last wins, pointer updates on grant; FIXED_PRI=1 -> req1.
// - START: strt_cnv = 1 for exactly this cycle; next edge -> WAIT.
// - WAIT: edge with cnv_cmplt=1 -> res <= a2d_res, err <= 0, go to DONE. cnv_cmplt outside WAIT ignored.
// - DONE: owner's done = 1 for one cycle, gnt still high; next edge -> IDLE, gnt cleared.
// - Requester drops req at the edge closing its done cycle; IDLE samples req one cycle later,
//   so a dropped req never re-triggers. Req still high in IDLE = new request (back-to-back allowed).
// - Minimum latency: req high at edge 0 -> strt_cnv cycle 1 -> done the cycle after cnv_cmplt is sampled.
// - Req deasserted mid-conversion: no abort; conversion completes, done still pulsed, res updated.
// - Non-owner req during START/WAIT/DONE: held pending, served from IDLE per tie rule.
// - Reset mid-operation: immediate return to reset state; late cnv_cmplt after reset ignored (IDLE).
// - chnl changes while owner: ignored (chnnl latched at grant).
// CONFIGURATION
// - A2D_TIMEOUT_EN defined: counter clears entering WAIT and increments each WAIT cycle;
//   reaching TIMEOUT-1 without cnv_cmplt -> DONE with err=1, res unchanged.
//   cnv_cmplt on that same edge wins (normal completion, err=0).
// - A2D_TIMEOUT_EN undefined: WAIT holds indefinitely; no counter built; err tied 0.
// TESTING
// - Reset, req0=1 chnl0=3, cnv_cmplt after 5 cycles with a2d_res=12'hA5C -> chnnl=3, one strt_cnv,
//   done0 one cycle, res=A5C.
// - req0, req1 asserted same edge from reset, FIXED_PRI=0 -> gnt0 first, then gnt1;
//   repeat tie -> gnt0 again. FIXED_PRI=1 -> gnt1 first every tie.
// - req1 asserted while req0 owner in WAIT -> req1 served immediately after DONE; gnt never both high.
// - rst_n low during WAIT, cnv_cmplt pulsed 2 cycles after release -> no done, res=0, state IDLE.
// - cnv_cmplt pulsed in IDLE and START -> ignored, res unchanged, no done.
// - A2D_TIMEOUT_EN, TIMEOUT=64, no cnv_cmplt -> done with err=1 after 64 WAIT cycles,
//   res keeps previous value; without macro -> busy stays high, err=0.

Source files
------------

// File: rtl/a2d_arbiter.sv
// -----------------------------------------------------------------------------
// a2d_arbiter
//   Shares one A2D converter between two requesters. Requester 0 is the
//   slide-pot channel scanner and requester 1 is an auxiliary sampler
//   (battery/temperature). The arbiter owns the conversion sequence:
//   pick a winner, drive its channel, pulse start, wait for completion and
//   hand back the result with a one-cycle done strobe.
//
// Parameters
//   RES_W     result width from the A2D
//   CH_W      channel select width
//   FIXED_PRI 0 = round-robin on ties, 1 = requester 1 always wins ties
//   TIMEOUT   WAIT-state cycle limit (only with A2D_TIMEOUT_EN)
//
// Optional feature macro
//   A2D_TIMEOUT_EN  when defined, a conversion that never completes is
//                   abandoned after TIMEOUT WAIT cycles and reported with
//                   err=1. When undefined, WAIT holds indefinitely and err
//                   is tied low.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req0/chnl0        requester 0 level request and channel
//   req1/chnl1        requester 1 level request and channel
//   gnt0/gnt1         owner indication (one-hot or zero)
//   done0/done1       one-cycle completion strobe to the owner
//   res               last conversion result, held until next completion
//   err               timeout flag, valid with the done strobe
//   busy              high in any state other than IDLE
//   strt_cnv          one-cycle start pulse to the A2D
//   chnnl             channel driven to the A2D, latched at grant
//   cnv_cmplt/a2d_res A2D completion strobe and result
//   dbg_state         current FSM state (0 IDLE, 1 START, 2 WAIT, 3 DONE)
//
// Handshake: a requester raises reqN (level) with chnlN stable. The arbiter
// answers with gntN, held from the grant through the DONE cycle, and pulses
// doneN for exactly one cycle with res/err valid. The requester drops reqN
// at the edge that closes the done cycle; IDLE only samples requests one
// cycle later, so a dropped request never re-triggers, while a request that
// is still high in IDLE is treated as a new one.
// -----------------------------------------------------------------------------
module a2d_arbiter #(
  parameter int RES_W     = 12,
  parameter int CH_W      = 3,
  parameter bit FIXED_PRI = 1'b0,
  parameter int TIMEOUT   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [CH_W-1:0]  chnl0,
  input  logic             req1,
  input  logic [CH_W-1:0]  chnl1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [RES_W-1:0] res,
  output logic             err,
  output logic             busy,
  output logic             strt_cnv,
  output logic [CH_W-1:0]  chnnl,
  input  logic             cnv_cmplt,
  input  logic [RES_W-1:0] a2d_res,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;   // 0 = requester 0, 1 = requester 1
  logic              last_q,  last_d;    // requester served most recently
  logic [CH_W-1:0]   chnnl_q, chnnl_d;
  logic [RES_W-1:0]  res_q,   res_d;
  logic              winner;

`ifdef A2D_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              timed_out;
`endif

  // Winner selection: a lone request wins outright; on a tie the
  // round-robin pointer favours whoever was not served last.
  always_comb begin
    winner = req1;
    if (req0 && req1) begin
      winner = FIXED_PRI ? 1'b1 : ~last_q;
    end
  end

`ifdef A2D_TIMEOUT_EN
  // Counter is zero on the first WAIT cycle; hitting TIMEOUT-1 there means
  // TIMEOUT WAIT cycles have elapsed without a completion.
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign cnt_d     = (state_q == ST_WAIT) ? cnt_q + 1'b1 : '0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      chnnl_q <= '0;
      res_q   <= '0;
`ifdef A2D_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      chnnl_q <= chnnl_d;
      res_q   <= res_d;
`ifdef A2D_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    chnnl_d = chnnl_q;
    res_d   = res_q;
`ifdef A2D_TIMEOUT_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          owner_d = winner;
          last_d  = winner;
          chnnl_d = winner ? chnl1 : chnl0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A completion on the same edge as the timeout takes priority.
        if (cnv_cmplt) begin
          res_d   = a2d_res;
`ifdef A2D_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = ST_DONE;
        end
`ifdef A2D_TIMEOUT_EN
        else if (timed_out) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode (Moore: depends only on registered state)
  always_comb begin
    busy     = (state_q != ST_IDLE);
    gnt0     = busy && !owner_q;
    gnt1     = busy &&  owner_q;
    strt_cnv = (state_q == ST_START);
    done0    = (state_q == ST_DONE) && !owner_q;
    done1    = (state_q == ST_DONE) &&  owner_q;
  end

  assign res       = res_q;
  assign chnnl     = chnnl_q;
  assign dbg_state = state_q;

`ifdef A2D_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
